rsa_xcel_naive_mul_rem: RTL and testbench
=========================================

# rsa_xcel_naive_mul_rem

Iterative modular multiplier that computes (a * b) mod n for 32-bit operands behind latency-insensitive val/rdy streams. It is the responder for the r/b multiply-remainder requests issued by the naive modular-exponentiation datapath, with one instance per requester. It uses a bit-serial interleaved algorithm with no hardware multiplier, and has one request in flight at a time.

## Interface
- No parameters; all widths are fixed at 32-bit operands.
- clk  input  1  clock; all state updates on its rising edge
- reset  input  1  asynchronous, active-low reset
- istream_msg  input  96  request: [31:0] a, [63:32] b, [95:64] n
- istream_val  input  1  request valid
- istream_rdy  output  1  request ready
- ostream_msg  output  32  result (a * b) mod n
- ostream_val  output  1  result valid
- ostream_rdy  input  1  result ready

## Operation
- States:
  - IDLE: istream_rdy=1. Transaction on istream_val & istream_rdy latches a, b, n.
  - REDUCE: 32 cycles. Computes a_red = a mod n by restoring remainder, MSB-first.
  - MULT: 32 cycles. Interleaved modular multiply, b MSB-first.
  - DONE: ostream_val=1. Moves to IDLE on ostream_rdy.
- Transitions:
  - IDLE -> REDUCE on request accept, n != 0. Sets bit counter = 31 and acc = 0.
  - IDLE -> DONE on request accept, n == 0. Result is defined as 0.
  - REDUCE -> MULT after the counter-0 step. Writes acc to a_red, reloads counter = 31, clears acc.
  - MULT -> DONE after the counter-0 step. Writes acc to the result register.
  - DONE -> IDLE when ostream_rdy=1.
- REDUCE step i (33-bit arithmetic):
  - t = {acc, a[i]}
  - if t >= n then t -= n
  - acc = t
- MULT step i (33-bit arithmetic):
  - t = {acc, 1'b0}; if t >= n then t -= n
  - if b[i] then t += a_red; if t >= n then t -= n
  - acc = t
- Invariant: acc < n after every step, so the upper bit of acc is always 0 when stored. The 33rd bit of intermediates must never be truncated; n up to 0xFFFFFFFF must be exact.
- istream_rdy = (state == IDLE). ostream_val = (state == DONE). Both are decoded from state only.
- ostream_msg is driven from the result register. It holds the last result until the next completion.

## Timing
- Reset asserted (reset=0), any state:
  - state = IDLE, counter = 0, acc = 0, result = 0.
  - ostream_val = 0, ostream_msg = 0, istream_rdy = 1.
- Reset mid-operation: the in-flight request is discarded and no result is emitted. The first cycle after deassertion accepts a new request.
- Latency, with the accept in cycle 0:
  - REDUCE occupies cycles 1–32, MULT occupies cycles 33–64.
  - ostream_val = 1 from cycle 65.
  - n == 0: ostream_val = 1 from cycle 1.
- Handshake:
  - Backpressure: while ostream_rdy=0 in DONE, ostream_val stays 1 and ostream_msg stays stable.
  - No accept while busy: istream_rdy=0 in REDUCE, MULT and DONE.
  - Minimum spacing: a new request is accepted no earlier than the cycle after the output transfer.
  - Throughput: one result per 66 cycles when there is no backpressure.
- istream_msg is sampled only on the accept edge; changes afterwards have no effect.
- No combinational path from istream_* or ostream_rdy to any output.

## Test plan
- a=3, b=5, n=7 -> ostream_msg=0x00000001 with ostream_val first high in cycle 65. istream_rdy is 0 during cycles 1–65.
- a=0xFFFFFFFF, b=0xFFFFFFFF, n=0xFFFFFFFB -> 0x00000010. Exercises a > n reduction; a_red=4.
- a=2, b=0x80000000, n=0x80000001 -> 0x7FFFFFFF. Exercises the 33-bit doubling overflow path.
- n=0 (any a, b) -> 0x00000000 with ostream_val in cycle 1. Then n=1, a=9, b=9 -> 0x00000000 at cycle 65.
- Backpressure: with ostream_rdy=0 for 10 cycles after completion, ostream_val and the result stay held and istream_rdy stays 0. Once ostream_rdy=1, the next request is accepted the following cycle.
- Reset: apply a 1-cycle reset=0 in cycle 20 of a request. No ostream_val follows, all outputs return to reset values, and a fresh request a=4, b=6, n=5 returns 0x00000004.

Source files
------------

// File: rtl/rsa_xcel_naive_mul_rem.sv
// rtl/rsa_xcel_naive_mul_rem.sv - bit-serial (a * b) mod n responder with val/rdy streams
module rsa_xcel_naive_mul_rem (
    input  logic        clk,
    input  logic        reset,
    input  logic [95:0] istream_msg,
    input  logic        istream_val,
    output logic        istream_rdy,
    output logic [31:0] ostream_msg,
    output logic        ostream_val,
    input  logic        ostream_rdy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        MULT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  counter;
    logic [31:0] acc;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] n_reg;
    logic [31:0] a_red;
    logic [31:0] result;

    // Intermediates are 33 bits wide so n up to 0xFFFFFFFF never loses the carry.
    logic [32:0] n_ext;
    logic [32:0] red_shift;
    logic [32:0] red_next;
    logic [32:0] mul_dbl;
    logic [32:0] mul_dbl_red;
    logic [32:0] mul_add;
    logic [32:0] mul_next;

    // Handshake signals depend on the state register only.
    assign istream_rdy = (state == IDLE);
    assign ostream_val = (state == DONE);
    assign ostream_msg = result;

    // One restoring-remainder step and one interleaved multiply step per cycle.
    always_comb begin
        n_ext       = {1'b0, n_reg};

        red_shift   = {acc, a_reg[counter]};
        red_next    = (red_shift >= n_ext) ? (red_shift - n_ext) : red_shift;

        mul_dbl     = {acc, 1'b0};
        mul_dbl_red = (mul_dbl >= n_ext) ? (mul_dbl - n_ext) : mul_dbl;
        mul_add     = b_reg[counter] ? (mul_dbl_red + {1'b0, a_red}) : mul_dbl_red;
        mul_next    = (mul_add >= n_ext) ? (mul_add - n_ext) : mul_add;
    end

    // Control FSM and datapath registers; acc < n holds after every step, so bit 32 is dropped safely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= 5'd0;
            acc     <= 32'd0;
            a_reg   <= 32'd0;
            b_reg   <= 32'd0;
            n_reg   <= 32'd0;
            a_red   <= 32'd0;
            result  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (istream_val) begin
                        a_reg <= istream_msg[31:0];
                        b_reg <= istream_msg[63:32];
                        n_reg <= istream_msg[95:64];
                        if (istream_msg[95:64] == 32'd0) begin
                            result <= 32'd0;
                            state  <= DONE;
                        end else begin
                            counter <= 5'd31;
                            acc     <= 32'd0;
                            state   <= REDUCE;
                        end
                    end
                end
                REDUCE: begin
                    if (counter == 5'd0) begin
                        a_red   <= red_next[31:0];
                        acc     <= 32'd0;
                        counter <= 5'd31;
                        state   <= MULT;
                    end else begin
                        acc     <= red_next[31:0];
                        counter <= counter - 5'd1;
                    end
                end
                MULT: begin
                    if (counter == 5'd0) begin
                        result <= mul_next[31:0];
                        acc    <= mul_next[31:0];
                        state  <= DONE;
                    end else begin
                        acc     <= mul_next[31:0];
                        counter <= counter - 5'd1;
                    end
                end
                DONE: begin
                    if (ostream_rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_xcel_naive_mul_rem.sv
// tb/tb_rsa_xcel_naive_mul_rem.sv - directed table-driven bench for rsa_xcel_naive_mul_rem
module tb_rsa_xcel_naive_mul_rem;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] istream_msg;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] ostream_msg;
    logic        ostream_val;
    logic        ostream_rdy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rsa_xcel_naive_mul_rem dut (
        .clk         (clk),
        .reset       (reset),
        .istream_msg (istream_msg),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .ostream_msg (ostream_msg),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] n;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one request, count cycles to ostream_val, and leave the DUT in DONE.
    task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [31:0] n,
                           input logic [31:0] exp_res, input int exp_lat, input string tag);
        int cyc;
        int guard;
        bit busy_bad;
        guard = 0;
        while (!istream_rdy && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        istream_msg = {n, b, a};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        istream_msg = '1;
        cyc = 1;
        busy_bad = 1'b0;
        while (!ostream_val && cyc < 300) begin
            if (istream_rdy) busy_bad = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (istream_rdy) busy_bad = 1'b1;
        check($sformatf("%s_latency", tag), cyc, exp_lat);
        check($sformatf("%s_result", tag), ostream_msg, exp_res);
        check($sformatf("%s_busy_rdy", tag), {31'd0, busy_bad}, 32'd0);
    endtask

    vec_t vecs[12];

    initial begin
        int cyc;
        bit saw_val;

        vecs[0]  = '{32'd3,          32'd5,          32'd7,          32'h00000001, 65};
        vecs[1]  = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFB,   32'h00000010, 65};
        vecs[2]  = '{32'd2,          32'h80000000,   32'h80000001,   32'h7FFFFFFF, 65};
        vecs[3]  = '{32'h12345678,   32'h9ABCDEF0,   32'd0,          32'h00000000, 1};
        vecs[4]  = '{32'd9,          32'd9,          32'd1,          32'h00000000, 65};
        vecs[5]  = '{32'd4,          32'd6,          32'd5,          32'h00000004, 65};
        vecs[6]  = '{32'd10,         32'd10,         32'd7,          32'h00000002, 65};
        vecs[7]  = '{32'h12345678,   32'd1,          32'hFFFFFFFF,   32'h12345678, 65};
        vecs[8]  = '{32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   32'h00000000, 65};
        vecs[9]  = '{32'hFFFFFFFE,   32'hFFFFFFFE,   32'hFFFFFFFF,   32'h00000001, 65};
        vecs[10] = '{32'd1000,       32'd1000,       32'd999,        32'h00000001, 65};
        vecs[11] = '{32'd0,          32'hDEADBEEF,   32'd13,         32'h00000000, 65};

        reset       = 1'b0;
        istream_msg = '0;
        istream_val = 1'b0;
        ostream_rdy = 1'b1;
        #12;
        check("rst_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("rst_ostream_msg", ostream_msg, 32'd0);
        check("rst_istream_rdy", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].a, vecs[i].b, vecs[i].n, vecs[i].exp_res, vecs[i].exp_lat,
                    $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 10 cycles, then next request accepted right after transfer.
        @(posedge clk); #1;
        ostream_rdy = 1'b0;
        run_req(32'd10, 32'd10, 32'd7, 32'h00000002, 65, "bp");
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_val%0d", k), {31'd0, ostream_val}, 32'd1);
            check($sformatf("bp_hold_msg%0d", k), ostream_msg, 32'h00000002);
            check($sformatf("bp_hold_rdy%0d", k), {31'd0, istream_rdy}, 32'd0);
        end
        ostream_rdy = 1'b1;
        istream_msg = {32'd5, 32'd6, 32'd4};
        istream_val = 1'b1;
        @(posedge clk); #1;
        check("bp_after_xfer_val", {31'd0, ostream_val}, 32'd0);
        check("bp_after_xfer_rdy", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk); #1;
        istream_val = 1'b0;
        check("bp_accepted_rdy", {31'd0, istream_rdy}, 32'd0);
        cyc = 1;
        while (!ostream_val && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_next_latency", cyc, 65);
        check("bp_next_result", ostream_msg, 32'h00000004);

        // Reset in cycle 20 of a request: discarded, outputs cleared, fresh request works.
        @(posedge clk); #1;
        istream_msg = {32'd7, 32'd5, 32'd3};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        repeat (19) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        #1;
        check("midrst_ostream_val", {31'd0, ostream_val}, 32'd0);
        check("midrst_ostream_msg", ostream_msg, 32'd0);
        check("midrst_istream_rdy", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        saw_val = 1'b0;
        istream_msg = {32'd5, 32'd6, 32'd4};
        istream_val = 1'b1;
        @(posedge clk); #1;
        istream_val = 1'b0;
        cyc = 1;
        while (!ostream_val && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("postrst_latency", cyc, 65);
        check("postrst_result", ostream_msg, 32'h00000004);
        @(posedge clk); #1;
        for (int k = 0; k < 70; k++) begin
            if (ostream_val) saw_val = 1'b1;
            @(posedge clk); #1;
        end
        check("postrst_no_stale_val", {31'd0, saw_val}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
